// File: rtl/forth_stack_if.sv
// forth_stack_if: operation/result bundle for one forth_stack instance.
// Optional build macro FORTH_STACK_HWM_EN adds hwm_clr and hwm.
interface forth_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             clear;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             error;
    logic [1:0]       err_code;
`ifdef FORTH_STACK_HWM_EN
    logic             hwm_clr;
    logic [DW-1:0]    hwm;
`endif

`ifdef FORTH_STACK_HWM_EN
    modport master (
        output clear, op_valid, op, din, hwm_clr,
        input  op_ready, tos, nos, depth, empty, full, error, err_code, hwm
    );
    modport slave (
        input  clear, op_valid, op, din, hwm_clr,
        output op_ready, tos, nos, depth, empty, full, error, err_code, hwm
    );
`else
    modport master (
        output clear, op_valid, op, din,
        input  op_ready, tos, nos, depth, empty, full, error, err_code
    );
    modport slave (
        input  clear, op_valid, op, din,
        output op_ready, tos, nos, depth, empty, full, error, err_code
    );
`endif
endinterface

// File: rtl/forth_stack.sv
// forth_stack: TOS-cached data/return stack. TOS lives in a register, the
// remaining DEPTH-1 entries in an array indexed by depth-1. Overflow and
// underflow park the unit in a sticky ERROR state until clear.
// Optional build macro FORTH_STACK_HWM_EN adds a high-water-mark output.
module forth_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    forth_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_PUSH    = 3'b001,
        OP_POP     = 3'b010,
        OP_REPL    = 3'b011,
        OP_POPREPL = 3'b100,
        OP_SWAP    = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_UNF  = 2'b10
    } err_e;

    typedef enum logic {
        ST_RUN,
        ST_ERROR
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             error_q, error_d;
    err_e             err_code_q, err_code_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] stack_mem [DEPTH-1];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [AW-1:0]    nos_idx;
    logic [WIDTH-1:0] nos_w;
    logic             fault;
    err_e             fault_code;

    assign nos_idx = AW'(depth_q - DW'(2));
    assign nos_w   = (depth_q >= DW'(2)) ? stack_mem[nos_idx] : '0;

    // Next-state decode: clear first, then legality check, then the op itself.
    always_comb begin
        state_d    = state_q;
        tos_d      = tos_q;
        depth_d    = depth_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        ready_d    = ready_q;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = tos_q;
        fault      = 1'b0;
        fault_code = ERR_NONE;

        if (bus.clear) begin
            state_d    = ST_RUN;
            tos_d      = '0;
            depth_d    = '0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            ready_d    = 1'b1;
        end else if (state_q == ST_RUN && bus.op_valid) begin
            case (bus.op)
                OP_PUSH: begin
                    if (depth_q == DEPTH_MAX) begin
                        fault      = 1'b1;
                        fault_code = ERR_OVF;
                    end else begin
                        if (depth_q != '0) begin
                            mem_we    = 1'b1;
                            mem_waddr = AW'(depth_q - DW'(1));
                        end
                        tos_d   = bus.din;
                        depth_d = depth_q + DW'(1);
                    end
                end
                OP_POP: begin
                    if (depth_q == '0) begin
                        fault      = 1'b1;
                        fault_code = ERR_UNF;
                    end else begin
                        tos_d   = (depth_q == DW'(1)) ? '0 : nos_w;
                        depth_d = depth_q - DW'(1);
                    end
                end
                OP_REPL: begin
                    if (depth_q == '0) begin
                        fault      = 1'b1;
                        fault_code = ERR_UNF;
                    end else begin
                        tos_d = bus.din;
                    end
                end
                OP_POPREPL: begin
                    if (depth_q < DW'(2)) begin
                        fault      = 1'b1;
                        fault_code = ERR_UNF;
                    end else begin
                        tos_d   = bus.din;
                        depth_d = depth_q - DW'(1);
                    end
                end
                OP_SWAP: begin
                    if (depth_q < DW'(2)) begin
                        fault      = 1'b1;
                        fault_code = ERR_UNF;
                    end else begin
                        tos_d     = nos_w;
                        mem_we    = 1'b1;
                        mem_waddr = nos_idx;
                    end
                end
                default: begin
                end
            endcase

            if (fault) begin
                state_d    = ST_ERROR;
                ready_d    = 1'b0;
                error_d    = 1'b1;
                err_code_d = fault_code;
            end
        end
    end

    // Control FSM and TOS/depth registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            tos_q      <= '0;
            depth_q    <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            tos_q      <= tos_d;
            depth_q    <= depth_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            ready_q    <= ready_d;
        end
    end

    // Array below TOS; not reset. Writes need depth>=1, and reset holds
    // depth at 0, so an op presented during reset cannot write here.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            stack_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.op_ready = ready_q;
    assign bus.tos      = tos_q;
    assign bus.nos      = nos_w;
    assign bus.depth    = depth_q;
    assign bus.empty    = (depth_q == '0);
    assign bus.full     = (depth_q == DEPTH_MAX);
    assign bus.error    = error_q;
    assign bus.err_code = err_code_q;

`ifdef FORTH_STACK_HWM_EN
    logic [DW-1:0] hwm_q, hwm_d;

    // High-water mark follows the post-op depth so it never lags depth.
    always_comb begin
        hwm_d = hwm_q;
        if (bus.clear) begin
            hwm_d = '0;
        end else if (bus.hwm_clr) begin
            hwm_d = depth_d;
        end else if (depth_d > hwm_q) begin
            hwm_d = depth_d;
        end
    end

    // High-water-mark register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign bus.hwm = hwm_q;
`endif
endmodule

// File: doc/forth_stack.md
Name: forth_stack

Overview:
Parametrised TOS-cached data/return stack unit for the next-generation stack core. The dedicated registers and arrays inside the core become one instance per stack, each generalised in width and depth. Each instance holds the top of stack in a register and the remaining entries in an array. It reports depth and full/empty, and detects overflow and underflow, which the current core does not. Used twice per core: one instance for the parameter stack, one for the return stack.

Parameters:
WIDTH, 16, data width in bits
DEPTH, 256, maximum number of entries including TOS; must be at least 2
DW, $clog2(DEPTH+1), width of the depth output (derived localparam)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear; empties the stack and clears the error
op_valid  in  1  an operation is presented this cycle
op_ready  out  1  operation will be accepted; low only in ERROR
op  in  3  000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 POPREPL, 101 SWAP, others NOP
din  in  WIDTH  data for PUSH, REPL and POPREPL
tos  out  WIDTH  top of stack, registered
nos  out  WIDTH  next-on-stack; combinational read of array[ptr-1]
depth  out  DW  current number of entries
empty  out  1  depth==0
full  out  1  depth==DEPTH
error  out  1  sticky error flag
err_code  out  2  00 none, 01 overflow, 10 underflow

Behaviour:
- Reset (async assert, sync deassert handled externally). Values: depth=0, tos=0, error=0, err_code=00, state RUN. Array contents are not reset.
- clear takes priority over op_valid. It gives the same register values as reset on the next edge.
- Storage:
  - TOS is a register.
  - Entries 2..DEPTH live in a (DEPTH-1)-entry array indexed by ptr = depth-1 when depth>=1.
  - nos is valid only when depth>=2, otherwise don't-care.
- An op is accepted when op_valid && op_ready && !clear. Results are visible one cycle after acceptance; there is no multi-cycle latency.
- Op semantics on acceptance:
  - PUSH: array[depth-1] <= tos when depth>=1; tos <= din; depth+1.
  - POP: tos <= nos (or 0 when depth==1); depth-1.
  - REPL: tos <= din; depth unchanged.
  - POPREPL: tos <= din; depth-1. This is the NOS-consuming binary ALU case.
  - SWAP: tos <= nos; array[depth-2] <= tos; depth unchanged.
  - NOP: no change.
- Legality checks, evaluated on the pre-op depth:
  - Overflow: PUSH when depth==DEPTH.
  - Underflow: POP or REPL when depth==0; POPREPL or SWAP when depth<2.
- Illegal op:
  - No state change to tos, depth or array.
  - error<=1, err_code set, FSM goes to ERROR.
- FSM states:
  - RUN: op_ready=1. Illegal op -> ERROR.
  - ERROR: op_ready=0; op_valid is ignored; tos, depth and err_code are held. clear -> RUN.
- Wrap-around is forbidden: depth never exceeds DEPTH and never goes below 0.
- Reset asserted mid-operation aborts the op. The in-flight op has no effect.

Optional Feature:
FORTH_STACK_HWM_EN
- Defined:
  - Adds output hwm [DW] holding the maximum depth reached since reset or clear.
  - hwm updates on the same edge as depth. It is cleared by reset or clear.
  - Adds input hwm_clr, which resets hwm to the current depth.
- Undefined: neither port exists and no logic is generated.

Test Plan:
- Push then pop: reset, then PUSH 0x1111, PUSH 0x2222, PUSH 0x3333 -> tos=0x3333, nos=0x2222, depth=3. Then POP twice -> tos=0x1111, depth=1, empty=0.
- Fill and overflow: with DEPTH=4, do 4 PUSHes -> full=1. A 5th PUSH -> error=1, err_code=01, depth=4, tos unchanged, op_ready=0. Then clear -> depth=0, error=0, op_ready=1.
- Underflow: POPREPL at depth=1 -> err_code=10, tos unchanged. Ops presented while in ERROR are ignored: a PUSH leaves depth=1.
- SWAP and POPREPL: stack [tos=5, nos=7]. SWAP -> tos=7, nos=5. Then POPREPL din=12 -> tos=12, depth=1.
- Reset mid-stream: assert reset_n=0 asynchronously between edges while a PUSH is presented -> outputs go to depth=0, tos=0 immediately, and no write lands.
- FORTH_STACK_HWM_EN: 3 PUSH, 2 POP -> hwm=3. Then hwm_clr -> hwm=1. Then clear -> hwm=0.
